// File: rtl/dmem_arb_pkg.sv
// Shared encodings, state enum and the memory geometry for the data-memory arbiter.
package dmem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    localparam int unsigned MEM_WORDS = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DATA,
        ST_RESP
    } state_t;

    // Alignment, size-encoding and range check for one request.
    function automatic logic access_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned addr_bits);
        logic e;
        e = ((addr >> addr_bits) != 32'd0);
        case (size)
            SZ_HALF: e = e | addr[0];
            SZ_WORD: e = e | (addr[1:0] != 2'b00);
            SZ_BAD:  e = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic: load extract/extend and store merge into the read word.
module dmem_lane_unit
    import dmem_arb_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] wshift;

    always_comb begin
        shamt     = {lane, 3'b000};
        shifted   = rdata >> shamt;
        wshift    = wdata << shamt;
        load_data = rdata;
        mask      = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
                mask      = 32'h0000_00FF << shamt;
            end
            SZ_HALF: begin
                load_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
                mask      = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        // A full-word size gives an all-ones mask, so the merge is just wdata.
        merge_data = (rdata & ~mask) | (wshift & mask);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sub-word access sequencer for the data memory.
// Define DMEM_ARB_RMW_EN to enable read-modify-write sub-word stores.
//
// state    | meaning
// ST_IDLE  | offer grant, latch request on handshake
// ST_ISSUE | drive address; word store writes here
// ST_DATA  | read word available: load response or sub-word merge write
// ST_RESP  | response pulse for stores and errored accesses
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = $clog2(MEM_WORDS * 4)
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][1:0]  req_size,
    input  logic [1:0]       req_unsigned,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    state_t      state;
    logic        last_q;
    logic        port_q;
    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        grant;
    logic [1:0]  grant_vec;
    logic [1:0]  port_vec;
    logic        handshake;
    logic        subword_err;
    logic        word_store;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = ~last_q;
        else if (req_valid[1])
            grant = 1'b1;
    end

    assign grant_vec  = req_valid[grant] ? (grant ? 2'b10 : 2'b01) : 2'b00;
    // Gated by rstn so ready drops the moment reset asserts.
    assign req_ready  = (state == ST_IDLE && rstn) ? grant_vec : 2'b00;
    assign handshake  = |(req_valid & req_ready);
    assign port_vec   = port_q ? 2'b10 : 2'b01;
    assign word_store = !err_q && we_q && (size_q == SZ_WORD);

`ifdef DMEM_ARB_RMW_EN
    assign subword_err = 1'b0;
`else
    assign subword_err = req_we[grant] &&
                         (req_size[grant] == SZ_BYTE || req_size[grant] == SZ_HALF);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        port_q  <= grant;
                        last_q  <= grant;
                        we_q    <= req_we[grant];
                        uns_q   <= req_unsigned[grant];
                        size_q  <= req_size[grant];
                        addr_q  <= req_addr[grant];
                        wdata_q <= req_wdata[grant];
                        err_q   <= access_err(req_size[grant], req_addr[grant], ADDR_BITS)
                                   | subword_err;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= (err_q || word_store) ? ST_RESP : ST_DATA;
                ST_DATA:  state <= we_q ? ST_RESP : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    dmem_lane_unit u_lane (
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    assign mem_addr = addr_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (word_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = merge_data;
                end
            end
            ST_DATA: begin
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = merge_data;
                end else begin
                    rsp_valid = port_vec;
                    rsp_rdata = load_data;
                end
            end
            ST_RESP: begin
                rsp_valid = port_vec;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_unsigned;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    logic [31:0] mem [0:255];
    int          checks = 0;
    int          failures = 0;
    logic        saw_we = 1'b0;
    logic        both_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            saw_we = 1'b1;
        end
        mem_rdata <= mem[mem_addr[9:2]];
    end

    always @(negedge clk) begin
        #1;
        if (req_ready === 2'b11) both_ready = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; lat counts cycles from handshake edge to rsp_valid.
    task automatic access(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        req_we[p]       = we;
        req_size[p]     = sz;
        req_unsigned[p] = uns;
        req_addr[p]     = addr;
        req_wdata[p]    = wd;
        req_valid[p]    = 1'b1;
        saw_we = 1'b0;
        n = 0;
        #1;
        while (!req_ready[p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready[p]) begin
            check("handshake_timeout", 32'd0, 32'd1);
            req_valid[p] = 1'b0;
            @(negedge clk);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[p] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (rsp_valid[p]) begin
                lat = c;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int p, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        int          lat;
        logic [31:0] rd;
        logic        er;
        access(p, we, sz, uns, addr, wd, lat, rd, er);
        check({tag, ".lat"},   lat, exp_lat);
        check({tag, ".rdata"}, rd,  exp_rd);
        check({tag, ".err"},   er,  exp_err);
    endtask

    logic [1:0] grants [0:3];
    int         k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rstn         = 1'b0;
        req_valid    = 2'b01;
        req_we       = '0;
        req_size     = '0;
        req_unsigned = '0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst.req_ready", req_ready, 2'b00);
        check("rst.rsp_valid", rsp_valid, 2'b00);
        check("rst.mem_we",    mem_we,    1'b0);
        check("rst.mem_addr",  mem_addr,  32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Both ports valid from reset: port 0 wins first tie, then alternate.
        req_size[0] = 2'd2; req_addr[0] = 32'h10;
        req_size[1] = 2'd2; req_addr[1] = 32'h20;
        req_valid   = 2'b11;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            #1;
            if ((req_ready & req_valid) != 2'b00) begin
                grants[k] = req_ready;
                k++;
            end
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        check("arb.count", k, 4);
        check("arb.g0", grants[0], 2'b01);
        check("arb.g1", grants[1], 2'b10);
        check("arb.g2", grants[2], 2'b01);
        check("arb.g3", grants[3], 2'b10);
        check("arb.never_both", both_ready, 1'b0);

        run("wst10", 0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        check("wst10.mem", mem[4], 32'hDEADBEEF);
        run("wld10", 0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        run("wst20", 0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 2, 32'h0, 1'b0);
        run("bst21", 0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, RMW ? 3 : 2, 32'h0, !RMW);
        check("bst21.mem", mem[8], RMW ? 32'h1122AA44 : 32'h11223344);
        check("bst21.we", saw_we, RMW);
        run("lbs21", 0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 2, RMW ? 32'hFFFFFFAA : 32'h00000033, 1'b0);
        run("lbu21", 0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 2, RMW ? 32'h000000AA : 32'h00000033, 1'b0);
        run("lhs22", 0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 2, 32'h00001122, 1'b0);

        run("wst40", 1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h8000F0F0, 2, 32'h0, 1'b0);
        run("lhs42", 1, 1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 2, 32'hFFFF8000, 1'b0);
        run("lhu40", 0, 1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 2, 32'h0000F0F0, 1'b0);
        run("lbs43", 1, 1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 2, 32'hFFFFFF80, 1'b0);
        run("lbs40", 0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 2, 32'hFFFFFFF0, 1'b0);
        run("hst42", 1, 1'b1, 2'd1, 1'b0, 32'h42, 32'h1234BEEF, RMW ? 3 : 2, 32'h0, !RMW);
        check("hst42.mem", mem[16], RMW ? 32'hBEEFF0F0 : 32'h8000F0F0);

        run("wst3fc", 1, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, 2, 32'h0, 1'b0);
        check("wst3fc.mem", mem[255], 32'hCAFEF00D);

        run("err_h03", 0, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 2, 32'h0, 1'b1);
        check("err_h03.we", saw_we, 1'b0);
        run("err_w402", 1, 1'b0, 2'd2, 1'b0, 32'h402, 32'h0, 2, 32'h0, 1'b1);
        check("err_w402.we", saw_we, 1'b0);
        run("err_sz3", 0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 2, 32'h0, 1'b1);
        check("err_sz3.we", saw_we, 1'b0);
        run("err_ws400", 0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 2, 32'h0, 1'b1);
        check("err_ws400.we", saw_we, 1'b0);
        check("err_ws400.mem", mem[0], 32'h0);

        // Reset two cycles after a byte-store handshake, when the merge write is on the bus.
        run("wst30", 0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h55555555, 2, 32'h0, 1'b0);
        req_we[0] = 1'b1; req_size[0] = 2'd0; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h30; req_wdata[0] = 32'hAA; req_valid[0] = 1'b1;
        #1;
        check("mid.ready", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        check("mid.pre_we", mem_we, RMW);
        rstn = 1'b0;
        #1;
        check("mid.req_ready", req_ready, 2'b00);
        check("mid.rsp_valid", rsp_valid, 2'b00);
        check("mid.rsp_rdata", rsp_rdata, 32'h0);
        check("mid.rsp_err",   rsp_err,   1'b0);
        check("mid.mem_we",    mem_we,    1'b0);
        check("mid.mem_addr",  mem_addr,  32'h0);
        check("mid.mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        check("mid.mem", mem[12], 32'h55555555);
        rstn = 1'b1;
        req_valid = 2'b11;
        #1;
        check("mid.first_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);
        run("ld30", 0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 2, 32'h55555555, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
